// File: rtl/gui_sprite_sequencer.sv
// gui_sprite_sequencer
// Picks which player sprite the OLED shows and composites it over the background.
// A hit starts an injury animation. The injured-1 sprite is held for INJ1_FRAMES
// frames. The injured-2 sprite then flickers for INJ2_FRAMES frames, and the
// sprite returns to idle. State only advances on frame_tick, so the ROM selection
// never changes in the middle of a frame.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   frame_tick    one-cycle pulse per displayed frame
//   hit           one-cycle pulse when the player is struck
//   clr_hits      synchronous clear of hit_count (wins over hit)
//   idle_colour   idle sprite ROM pixel, RGB565
//   inj1_colour   injured-1 sprite ROM pixel, RGB565
//   inj2_colour   injured-2 sprite ROM pixel, RGB565
//   bg_colour     background pixel, RGB565
//   sprite_sel    00 idle, 01 inj1, 10 inj2 (selects the external ROM)
//   oled_colour   registered composited pixel
//   busy          high while an injury animation is running
//   hit_count     saturating (0..15) count of hits
module gui_sprite_sequencer #(
  parameter int          INJ1_FRAMES = 6,
  parameter int          INJ2_FRAMES = 6,
  parameter logic [15:0] KEY_COLOUR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        clr_hits,
  input  logic [15:0] idle_colour,
  input  logic [15:0] inj1_colour,
  input  logic [15:0] inj2_colour,
  input  logic [15:0] bg_colour,
  output logic [1:0]  sprite_sel,
  output logic [15:0] oled_colour,
  output logic        busy,
  output logic [3:0]  hit_count
);

  localparam int MAX_FRAMES = (INJ1_FRAMES > INJ2_FRAMES) ? INJ1_FRAMES : INJ2_FRAMES;
  localparam int FW         = $clog2(MAX_FRAMES + 1);

  localparam logic [FW-1:0] INJ1_LAST = FW'(INJ1_FRAMES - 1);
  localparam logic [FW-1:0] INJ2_LAST = FW'(INJ2_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INJ1 = 2'd1,
    INJ2 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          hit_pend, hit_pend_nxt;
  logic [15:0]   sel_colour;

  // State register. A reset abandons any running animation and drops a pending hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fcnt     <= '0;
      hit_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      hit_pend <= hit_pend_nxt;
    end
  end

  // Next-state logic. A hit between ticks is remembered in hit_pend and acted on at
  // the next tick. A hit that arrives on the tick itself takes effect immediately and
  // is never latched. Any hit restarts the animation at the first injured-1 frame.
  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    hit_pend_nxt = hit_pend;
    if (frame_tick) begin
      hit_pend_nxt = 1'b0;
      if (hit_pend || hit) begin
        state_nxt = INJ1;
        fcnt_nxt  = '0;
      end else begin
        case (state)
          INJ1: begin
            if (fcnt == INJ1_LAST) begin
              state_nxt = INJ2;
              fcnt_nxt  = '0;
            end else begin
              fcnt_nxt = fcnt + 1'b1;
            end
          end
          INJ2: begin
            if (fcnt == INJ2_LAST) begin
              state_nxt = IDLE;
              fcnt_nxt  = '0;
            end else begin
              fcnt_nxt = fcnt + 1'b1;
            end
          end
          default: begin
            state_nxt = IDLE;
            fcnt_nxt  = '0;
          end
        endcase
      end
    end else if (hit) begin
      hit_pend_nxt = 1'b1;
    end
  end

  // Outputs decoded from registered state only. In INJ2 the sprite alternates
  // with idle on odd frames to produce the flicker.
  always_comb begin
    sprite_sel = 2'b00;
    busy       = (state != IDLE);
    case (state)
      INJ1:    sprite_sel = 2'b01;
      INJ2:    sprite_sel = fcnt[0] ? 2'b00 : 2'b10;
      default: sprite_sel = 2'b00;
    endcase
  end

  always_comb begin
    case (sprite_sel)
      2'b01:   sel_colour = inj1_colour;
      2'b10:   sel_colour = inj2_colour;
      default: sel_colour = idle_colour;
    endcase
  end

  // Transparency compositing: the key colour shows the background through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oled_colour <= 16'h0000;
    end else begin
      oled_colour <= (sel_colour == KEY_COLOUR) ? bg_colour : sel_colour;
    end
  end

  // Hit counter saturates at 15. A clear in the same cycle as a hit discards the hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= 4'd0;
    end else if (clr_hits) begin
      hit_count <= 4'd0;
    end else if (hit && (hit_count != 4'hF)) begin
      hit_count <= hit_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_gui_sprite_sequencer.sv
// tb_gui_sprite_sequencer
// Drives two sequencer instances from the same stimulus. Instance A uses the
// default parameters. Instance B holds each injured state for one frame and uses a
// non-zero key colour. A frame-level reference model tracks the animation as
// "frames elapsed since the last hit", and its outputs are compared against both
// DUTs on every falling edge. Hand-computed literal checks pin down the model.
module tb_gui_sprite_sequencer;

  localparam logic [15:0] KEY_B = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        hit = 1'b0;
  logic        clr_hits = 1'b0;
  logic [15:0] idle_colour = 16'h0000;
  logic [15:0] inj1_colour = 16'h1111;
  logic [15:0] inj2_colour = 16'h2222;
  logic [15:0] bg_colour = 16'h0BB0;

  logic [1:0]  sel_a, sel_b;
  logic [15:0] oled_a, oled_b;
  logic        busy_a, busy_b;
  logic [3:0]  cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  int          m_phase [2];
  logic [15:0] m_oled  [2];
  bit          m_pend  [2];
  int          m_count;

  always #5 clk = ~clk;

  gui_sprite_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit(hit), .clr_hits(clr_hits),
    .idle_colour(idle_colour), .inj1_colour(inj1_colour), .inj2_colour(inj2_colour),
    .bg_colour(bg_colour), .sprite_sel(sel_a), .oled_colour(oled_a), .busy(busy_a),
    .hit_count(cnt_a)
  );

  gui_sprite_sequencer #(.INJ1_FRAMES(1), .INJ2_FRAMES(1), .KEY_COLOUR(KEY_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit(hit), .clr_hits(clr_hits),
    .idle_colour(idle_colour), .inj1_colour(inj1_colour), .inj2_colour(inj2_colour),
    .bg_colour(bg_colour), .sprite_sel(sel_b), .oled_colour(oled_b), .busy(busy_b),
    .hit_count(cnt_b)
  );

  // Model parameters per instance.
  function automatic int n1(int i);
    return (i == 0) ? 6 : 1;
  endfunction

  function automatic int n2(int i);
    return (i == 0) ? 6 : 1;
  endfunction

  function automatic logic [15:0] key_of(int i);
    return (i == 0) ? 16'h0000 : KEY_B;
  endfunction

  // Phase is -1 when idle. Otherwise it is the number of ticks since the animation
  // (re)started: phases 0..n1-1 show injured-1 and the next n2 phases show injured-2.
  function automatic int next_phase(int ph, bit pend, bit h, bit t, int a, int b);
    if (!t)               return ph;
    if (pend || h)        return 0;
    if (ph < 0)           return -1;
    if (ph + 1 >= a + b)  return -1;
    return ph + 1;
  endfunction

  function automatic logic [1:0] sel_of(int ph, int a);
    if (ph < 0) return 2'b00;
    if (ph < a) return 2'b01;
    return (((ph - a) % 2) == 0) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [15:0] pick(logic [1:0] s);
    if (s == 2'b01) return inj1_colour;
    if (s == 2'b10) return inj2_colour;
    return idle_colour;
  endfunction

  function automatic logic [15:0] rand_col();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 16'h0000;
    if (r == 1) return KEY_B;
    return 16'($urandom);
  endfunction

  // Reference model, advanced on each rising edge from the inputs held stable since the falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] <= -1;
        m_pend[i]  <= 1'b0;
        m_oled[i]  <= 16'h0000;
      end
    end else begin
      if (clr_hits)                  m_count <= 0;
      else if (hit && m_count < 15)  m_count <= m_count + 1;
      for (int i = 0; i < 2; i++) begin
        m_oled[i]  <= (pick(sel_of(m_phase[i], n1(i))) == key_of(i)) ?
                      bg_colour : pick(sel_of(m_phase[i], n1(i)));
        m_phase[i] <= next_phase(m_phase[i], m_pend[i], hit, frame_tick, n1(i), n2(i));
        m_pend[i]  <= frame_tick ? 1'b0 : (m_pend[i] | hit);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("a.sprite_sel",  16'(sel_a),  16'(sel_of(m_phase[0], n1(0))));
      checkOutput("a.busy",        16'(busy_a), 16'(m_phase[0] >= 0));
      checkOutput("a.hit_count",   16'(cnt_a),  16'(m_count));
      checkOutput("a.oled_colour", oled_a,      m_oled[0]);
      checkOutput("b.sprite_sel",  16'(sel_b),  16'(sel_of(m_phase[1], n1(1))));
      checkOutput("b.busy",        16'(busy_b), 16'(m_phase[1] >= 0));
      checkOutput("b.hit_count",   16'(cnt_b),  16'(m_count));
      checkOutput("b.oled_colour", oled_b,      m_oled[1]);
    end
  end

  // Waits for the falling edge, then drives the control inputs for the next rising edge.
  task automatic applyStimulus(input bit t, input bit h, input bit c);
    @(negedge clk);
    frame_tick = t;
    hit        = h;
    clr_hits   = c;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0;
    hit = 1'b0;
    clr_hits = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();
    checkOutput("reset.sprite_sel",  16'(sel_a),  16'h0);
    checkOutput("reset.busy",        16'(busy_a), 16'h0);
    checkOutput("reset.hit_count",   16'(cnt_a),  16'h0);
    checkOutput("reset.oled_colour", oled_a,      16'h0000);
    cmp_en = 1'b1;

    // Full animation: hit at cycle 10, a frame tick every 100 cycles from cycle 50.
    // At iteration c the outputs reflect the inputs of iteration c-1.
    for (int c = 0; c < 1300; c++) begin
      applyStimulus((c >= 50) && (((c - 50) % 100) == 0), c == 10, 1'b0);
      if (c == 12)   checkOutput("anim.count_after_hit", 16'(cnt_a), 16'd1);
      if (c == 51)   checkOutput("anim.sel_tick50",  16'(sel_a), 16'h1);
      if (c == 651)  checkOutput("anim.sel_tick650", 16'(sel_a), 16'h2);
      if (c == 751)  checkOutput("anim.sel_tick750", 16'(sel_a), 16'h0);
      if (c == 851)  checkOutput("anim.sel_tick850", 16'(sel_a), 16'h2);
      if (c == 1250) checkOutput("anim.busy_last_frame", 16'(busy_a), 16'h1);
      if (c == 1251) begin
        checkOutput("anim.sel_done",  16'(sel_a),  16'h0);
        checkOutput("anim.busy_done", 16'(busy_a), 16'h0);
      end
    end

    // Hit and tick in the same cycle from idle: immediate INJ1 with nothing left pending,
    // so INJ2 is reached after exactly six further ticks.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("same_cycle.sel", 16'(sel_a), 16'h1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("same_cycle.inj2_on_time", 16'(sel_a), 16'h2);

    // Retrigger from INJ2 with fcnt=3.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("retrig.inj2_f3_sel",  16'(sel_a),  16'h0);
    checkOutput("retrig.inj2_f3_busy", 16'(busy_a), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("retrig.sel",   16'(sel_a), 16'h1);
    checkOutput("retrig.count", 16'(cnt_a), 16'd2);

    // Asynchronous reset in the middle of INJ1, between clock edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst.sel",   16'(sel_a),  16'h0);
    checkOutput("async_rst.busy",  16'(busy_a), 16'h0);
    checkOutput("async_rst.oled",  oled_a,      16'h0000);
    checkOutput("async_rst.count", 16'(cnt_a),  16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Transparency key and a near-key colour, one cycle of latency.
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle_colour = 16'h0000;
    bg_colour   = 16'h1234;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("key.bg_shown", oled_a, 16'h1234);
    idle_colour = 16'hFFDF;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("key.sprite_shown", oled_a, 16'hFFDF);

    // Saturation, then a clear together with a hit.
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("count.saturate", 16'(cnt_a), 16'd15);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("count.clear_wins", 16'(cnt_a), 16'd0);

    // Randomized traffic with colours often equal to either key, plus one mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 2);
      idle_colour = rand_col();
      inj1_colour = rand_col();
      inj2_colour = rand_col();
      bg_colour   = 16'($urandom);
      if (c == 2000) begin
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rand_rst.busy", 16'(busy_a), 16'h0);
        checkOutput("rand_rst.sel",  16'(sel_b),  16'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
